// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the exception/commit controller: CP0 exception
// codes, exception vectors, FSM state encoding and the bad-address source
// selector produced by the priority encoder.
// Optional feature macro: EXC_TRAP_EN (adds the Tr exception, code 0x0D).
package exc_commit_ctrl_pkg;

   // CP0 Cause.ExcCode values
   localparam logic [4:0] EXC_Int  = 5'h00;
   localparam logic [4:0] EXC_AdEL = 5'h04;
   localparam logic [4:0] EXC_AdES = 5'h05;
   localparam logic [4:0] EXC_Sys  = 5'h08;
   localparam logic [4:0] EXC_Bp   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0A;
   localparam logic [4:0] EXC_Ov   = 5'h0C;
   localparam logic [4:0] EXC_Tr   = 5'h0D;

   // Exception entry points, selected by Status.BEV
   localparam logic [31:0] EXC_VEC_BEV0_DEF = 32'h8000_0180;
   localparam logic [31:0] EXC_VEC_BEV1_DEF = 32'hBFC0_0380;

   // Controller states: accepting commits, or waiting for fetch to take a redirect
   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } state_t;

   // Which value is reported as BadVAddr for the winning exception
   typedef enum logic [1:0] {
      BADV_NONE  = 2'd0,
      BADV_PC    = 2'd1,
      BADV_DADDR = 2'd2
   } badv_sel_t;

   // EPC of an instruction: a delay-slot instruction restarts at its branch
   function automatic logic [31:0] epcOf(input logic [31:0] pc, input logic bd);
      return bd ? (pc - 32'd4) : pc;
   endfunction

endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Combinational exception priority encoder. Turns the sampled interrupt
// and the MEM-stage exception flags into a single winning cause: whether
// any cause is present, its ExcCode, and where BadVAddr comes from.
// Optional feature macro: EXC_TRAP_EN (adds i_tr between Ov and Sys).
module exc_prio_enc
   import exc_commit_ctrl_pkg::*;
(
   input  logic       i_int_pend,
   input  logic       i_adel_if,
   input  logic       i_ri,
   input  logic       i_ov,
`ifdef EXC_TRAP_EN
   input  logic       i_tr,
`endif
   input  logic       i_sys,
   input  logic       i_bp,
   input  logic       i_adel_ld,
   input  logic       i_ades,
   output logic       o_any,
   output logic [4:0] o_excode,
   output badv_sel_t  o_badv_sel
);

   // Fixed-priority selection; the interrupt outranks every synchronous cause
   always_comb begin
      o_any      = 1'b1;
      o_excode   = EXC_Int;
      o_badv_sel = BADV_NONE;
      if (i_int_pend) begin
         o_excode = EXC_Int;
      end else if (i_adel_if) begin
         o_excode   = EXC_AdEL;
         o_badv_sel = BADV_PC;
      end else if (i_ri) begin
         o_excode = EXC_RI;
      end else if (i_ov) begin
         o_excode = EXC_Ov;
`ifdef EXC_TRAP_EN
      end else if (i_tr) begin
         o_excode = EXC_Tr;
`endif
      end else if (i_sys) begin
         o_excode = EXC_Sys;
      end else if (i_bp) begin
         o_excode = EXC_Bp;
      end else if (i_adel_ld) begin
         o_excode   = EXC_AdEL;
         o_badv_sel = BADV_DADDR;
      end else if (i_ades) begin
         o_excode   = EXC_AdES;
         o_badv_sel = BADV_DADDR;
      end else begin
         o_any = 1'b0;
      end
   end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/commit arbiter between MEM and CP0. Picks the winning
// exception (or ERET) of the MEM instruction, issues the single-cycle CP0
// commit and pipeline flush, then holds a redirect to fetch until it is
// accepted. No further commits happen while the redirect is outstanding.
// Optional feature macro: EXC_TRAP_EN (adds input ms_tr / Tr exception).
module exc_commit_ctrl
   import exc_commit_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VEC_BEV0 = EXC_VEC_BEV0_DEF,
   parameter logic [31:0] EXC_VEC_BEV1 = EXC_VEC_BEV1_DEF
)(
   input  logic        clk,
   input  logic        resetn,
   input  logic        ms_valid,
   input  logic [31:0] ms_pc,
   input  logic        ms_bd,
   input  logic [31:0] ms_daddr,
   input  logic        ms_adel_if,
   input  logic        ms_ri,
   input  logic        ms_ov,
`ifdef EXC_TRAP_EN
   input  logic        ms_tr,
`endif
   input  logic        ms_sys,
   input  logic        ms_bp,
   input  logic        ms_adel_ld,
   input  logic        ms_ades,
   input  logic        ms_eret,
   input  logic        int_req,
   input  logic        cp0_bev,
   input  logic [31:0] cp0_epc,
   output logic        ms_commit_ok,
   output logic        exc_valid,
   output logic        exc_bd,
   output logic        exc_eret,
   output logic [4:0]  exc_excode,
   output logic [31:0] exc_epc,
   output logic [31:0] exc_badvaddr,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_int_pend;
   logic        w_int_pend_nxt;
   logic        r_redirect_valid;
   logic        w_redirect_valid_nxt;
   logic [31:0] r_redirect_pc;
   logic [31:0] w_redirect_pc_nxt;

   logic        w_any;
   logic [4:0]  w_excode;
   badv_sel_t   w_badv_sel;
   logic        w_take;
   logic        w_ret;

   exc_prio_enc u_prio_enc (
      .i_int_pend (r_int_pend),
      .i_adel_if  (ms_adel_if),
      .i_ri       (ms_ri),
      .i_ov       (ms_ov),
`ifdef EXC_TRAP_EN
      .i_tr       (ms_tr),
`endif
      .i_sys      (ms_sys),
      .i_bp       (ms_bp),
      .i_adel_ld  (ms_adel_ld),
      .i_ades     (ms_ades),
      .o_any      (w_any),
      .o_excode   (w_excode),
      .o_badv_sel (w_badv_sel)
   );

   // Next-state and zero-latency commit outputs; commits only happen in IDLE
   always_comb begin
      w_state_nxt          = r_state;
      w_int_pend_nxt       = int_req;
      w_redirect_valid_nxt = r_redirect_valid;
      w_redirect_pc_nxt    = r_redirect_pc;
      w_take               = 1'b0;
      w_ret                = 1'b0;
      ms_commit_ok         = 1'b0;
      exc_valid            = 1'b0;
      exc_bd               = 1'b0;
      exc_eret             = 1'b0;
      exc_excode           = EXC_Int;
      exc_epc              = 32'd0;
      exc_badvaddr         = 32'd0;
      flush                = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ms_commit_ok = 1'b1;
            w_take       = ms_valid && w_any;
            w_ret        = ms_valid && ms_eret && !w_take;
            if (w_take || w_ret) begin
               exc_valid  = 1'b1;
               exc_eret   = w_ret;
               exc_excode = w_take ? w_excode : EXC_Int;
               exc_bd     = ms_bd;
               exc_epc    = epcOf(ms_pc, ms_bd);
               if (w_take) begin
                  case (w_badv_sel)
                     BADV_PC:    exc_badvaddr = ms_pc;
                     BADV_DADDR: exc_badvaddr = ms_daddr;
                     default:    exc_badvaddr = 32'd0;
                  endcase
               end
               flush                = 1'b1;
               w_state_nxt          = ST_REDIRECT;
               w_int_pend_nxt       = 1'b0;
               w_redirect_valid_nxt = 1'b1;
               if (w_take) begin
                  w_redirect_pc_nxt = cp0_bev ? EXC_VEC_BEV1 : EXC_VEC_BEV0;
               end else begin
                  w_redirect_pc_nxt = cp0_epc;
               end
            end
         end
         ST_REDIRECT: begin
            w_int_pend_nxt = 1'b0;
            if (r_redirect_valid && redirect_ready) begin
               w_state_nxt          = ST_IDLE;
               w_redirect_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt          = ST_IDLE;
            w_int_pend_nxt       = 1'b0;
            w_redirect_valid_nxt = 1'b0;
         end
      endcase
   end

   // State, interrupt sample and redirect request registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state          <= ST_IDLE;
         r_int_pend       <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 32'd0;
      end else begin
         r_state          <= w_state_nxt;
         r_int_pend       <= w_int_pend_nxt;
         r_redirect_valid <= w_redirect_valid_nxt;
         r_redirect_pc    <= w_redirect_pc_nxt;
      end
   end

   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: a table of single-instruction
// commit cases plus hand-written sequences for redirect stalls, interrupt
// masking during redirect, async reset and (optionally) the Tr exception.
// Redirect targets go through a scoreboard queue.
module tb_exc_commit_ctrl;

   logic        clk;
   logic        resetn;
   logic        ms_valid;
   logic [31:0] ms_pc;
   logic        ms_bd;
   logic [31:0] ms_daddr;
   logic        ms_adel_if, ms_ri, ms_ov, ms_sys, ms_bp, ms_adel_ld, ms_ades;
`ifdef EXC_TRAP_EN
   logic        ms_tr;
`endif
   logic        ms_eret;
   logic        int_req;
   logic        cp0_bev;
   logic [31:0] cp0_epc;
   logic        ms_commit_ok;
   logic        exc_valid, exc_bd, exc_eret;
   logic [4:0]  exc_excode;
   logic [31:0] exc_epc, exc_badvaddr;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;

   int errors = 0;
   int checks = 0;
   logic [31:0] sbq[$];

   // flags order: {adel_if, ri, ov, sys, bp, adel_ld, ades}
   typedef struct {
      logic        intr;
      logic        valid;
      logic        bd;
      logic [31:0] pc;
      logic [31:0] daddr;
      logic [6:0]  flags;
      logic        eret;
      logic        bev;
      logic [31:0] epcIn;
      logic        expValid;
      logic [4:0]  expCode;
      logic        expEret;
      logic [31:0] expEpc;
      logic [31:0] expBadv;
      logic [31:0] expRpc;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs[NVEC];

   exc_commit_ctrl dut (
      .clk            (clk),
      .resetn         (resetn),
      .ms_valid       (ms_valid),
      .ms_pc          (ms_pc),
      .ms_bd          (ms_bd),
      .ms_daddr       (ms_daddr),
      .ms_adel_if     (ms_adel_if),
      .ms_ri          (ms_ri),
      .ms_ov          (ms_ov),
`ifdef EXC_TRAP_EN
      .ms_tr          (ms_tr),
`endif
      .ms_sys         (ms_sys),
      .ms_bp          (ms_bp),
      .ms_adel_ld     (ms_adel_ld),
      .ms_ades        (ms_ades),
      .ms_eret        (ms_eret),
      .int_req        (int_req),
      .cp0_bev        (cp0_bev),
      .cp0_epc        (cp0_epc),
      .ms_commit_ok   (ms_commit_ok),
      .exc_valid      (exc_valid),
      .exc_bd         (exc_bd),
      .exc_eret       (exc_eret),
      .exc_excode     (exc_excode),
      .exc_epc        (exc_epc),
      .exc_badvaddr   (exc_badvaddr),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clearInputs();
      ms_valid   = 1'b0;
      ms_pc      = 32'd0;
      ms_bd      = 1'b0;
      ms_daddr   = 32'd0;
      {ms_adel_if, ms_ri, ms_ov, ms_sys, ms_bp, ms_adel_ld, ms_ades} = 7'd0;
`ifdef EXC_TRAP_EN
      ms_tr      = 1'b0;
`endif
      ms_eret    = 1'b0;
      int_req    = 1'b0;
      cp0_bev    = 1'b0;
      cp0_epc    = 32'd0;
   endtask

   task automatic applyStimulus(input vec_t v);
      ms_valid = v.valid;
      ms_pc    = v.pc;
      ms_bd    = v.bd;
      ms_daddr = v.daddr;
      {ms_adel_if, ms_ri, ms_ov, ms_sys, ms_bp, ms_adel_ld, ms_ades} = v.flags;
      ms_eret  = v.eret;
      int_req  = 1'b0;
      cp0_bev  = v.bev;
      cp0_epc  = v.epcIn;
      if (v.expValid) sbq.push_back(v.expRpc);
   endtask

   // Wait (bounded) for a redirect, compare it with the scoreboard, then accept it
   task automatic drainRedirect(input string name);
      logic [31:0] expPc;
      for (int k = 0; k < 8 && !redirect_valid; k++) @(negedge clk);
      expPc = (sbq.size() > 0) ? sbq.pop_front() : 32'hDEAD_BEEF;
      if (!redirect_valid) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s redirect timeout: got 0 expected 1", name);
      end else begin
         checkOutput({name, " redirect_pc"}, redirect_pc, expPc);
      end
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      redirect_ready = 1'b0;
      @(negedge clk);
      checkOutput({name, " redirect dropped"}, {31'd0, redirect_valid}, 32'd0);
      checkOutput({name, " commit_ok back"}, {31'd0, ms_commit_ok}, 32'd1);
   endtask

   task automatic runVec(input int idx);
      vec_t  v;
      string nm;
      v  = vecs[idx];
      nm = $sformatf("row%0d", idx);
      @(posedge clk); #1;
      clearInputs();
      int_req = v.intr;
      @(posedge clk); #1;
      applyStimulus(v);
      @(negedge clk);
      checkOutput({nm, " exc_valid"}, {31'd0, exc_valid}, {31'd0, v.expValid});
      checkOutput({nm, " excode"}, {27'd0, exc_excode}, {27'd0, v.expCode});
      checkOutput({nm, " exc_eret"}, {31'd0, exc_eret}, {31'd0, v.expEret});
      checkOutput({nm, " exc_bd"}, {31'd0, exc_bd}, {31'd0, v.expValid & v.bd});
      checkOutput({nm, " exc_epc"}, exc_epc, v.expEpc);
      checkOutput({nm, " badvaddr"}, exc_badvaddr, v.expBadv);
      checkOutput({nm, " flush"}, {31'd0, flush}, {31'd0, v.expValid});
      checkOutput({nm, " commit_ok"}, {31'd0, ms_commit_ok}, 32'd1);
      @(posedge clk); #1;
      clearInputs();
      @(negedge clk);
      if (v.expValid) begin
         drainRedirect(nm);
      end else begin
         checkOutput({nm, " no redirect"}, {31'd0, redirect_valid}, 32'd0);
      end
   endtask

   initial begin
      //            intr valid bd pc            daddr         flags       eret bev epcIn          expV code   eret expEpc        expBadv       expRpc
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'hBFC0_0100, 32'h0,         7'b0010000, 1'b0, 1'b1, 32'h0,         1'b1, 5'h0C, 1'b0, 32'hBFC0_0100, 32'h0,         32'hBFC0_0380};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'h8000_1001, 7'b0000010, 1'b0, 1'b0, 32'h0,         1'b1, 5'h04, 1'b0, 32'h8000_000C, 32'h8000_1001, 32'h8000_0180};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h8000_0040, 32'h0,         7'b0001000, 1'b0, 1'b0, 32'h0,         1'b1, 5'h00, 1'b0, 32'h8000_0040, 32'h0,         32'h8000_0180};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0300, 32'h0,         7'b0000000, 1'b1, 1'b0, 32'h8000_2000, 1'b1, 5'h00, 1'b1, 32'h8000_0300, 32'h0,         32'h8000_2000};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0304, 32'h0,         7'b0100000, 1'b1, 1'b0, 32'h8000_2000, 1'b1, 5'h0A, 1'b0, 32'h8000_0304, 32'h0,         32'h8000_0180};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0400, 32'h0,         7'b0000000, 1'b0, 1'b0, 32'h0,         1'b0, 5'h00, 1'b0, 32'h0,         32'h0,         32'h0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0123, 32'h1234_5678, 7'b1000000, 1'b0, 1'b1, 32'h0,         1'b1, 5'h04, 1'b0, 32'h8000_0123, 32'h8000_0123, 32'hBFC0_0380};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0500, 32'h8000_0FF2, 7'b0000001, 1'b0, 1'b0, 32'h0,         1'b1, 5'h05, 1'b0, 32'h8000_0500, 32'h8000_0FF2, 32'h8000_0180};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h8000_0600, 32'h0,         7'b0000100, 1'b0, 1'b0, 32'h0,         1'b1, 5'h09, 1'b0, 32'h8000_05FC, 32'h0,         32'h8000_0180};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0700, 32'h0,         7'b0001000, 1'b0, 1'b1, 32'h0,         1'b1, 5'h08, 1'b0, 32'h8000_0700, 32'h0,         32'hBFC0_0380};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h8000_0800, 32'h8000_0900, 7'b1100001, 1'b0, 1'b0, 32'h0,         1'b1, 5'h04, 1'b0, 32'h8000_0800, 32'h8000_0800, 32'h8000_0180};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0,         7'b0001000, 1'b0, 1'b0, 32'h0,         1'b1, 5'h08, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h8000_0180};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h8000_0900, 32'h0,         7'b0010000, 1'b1, 1'b0, 32'h0,         1'b0, 5'h00, 1'b0, 32'h0,         32'h0,         32'h0};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h8000_0A00, 32'h8000_0B00, 7'b0000010, 1'b1, 1'b1, 32'h8000_2000, 1'b1, 5'h00, 1'b0, 32'h8000_09FC, 32'h0,         32'hBFC0_0380};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h8000_0C00, 32'h8000_0D00, 7'b0011110, 1'b0, 1'b0, 32'h0,         1'b1, 5'h0C, 1'b0, 32'h8000_0C00, 32'h0,         32'h8000_0180};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h8000_0E00, 32'h0,         7'b0000000, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 5'h00, 1'b1, 32'h8000_0DFC, 32'h0,         32'h1234_5678};

      resetn         = 1'b0;
      redirect_ready = 1'b0;
      clearInputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
      checkOutput("reset redirect_pc", redirect_pc, 32'd0);
      checkOutput("reset commit_ok", {31'd0, ms_commit_ok}, 32'd1);
      checkOutput("reset exc_valid", {31'd0, exc_valid}, 32'd0);
      checkOutput("reset flush", {31'd0, flush}, 32'd0);
      resetn = 1'b1;

      for (int i = 0; i < NVEC; i++) runVec(i);

      // Stalled redirect: outputs hold, commits blocked even with exceptions/ERET
      // pending, and an interrupt requested during REDIRECT is not taken afterwards
      @(posedge clk); #1;
      clearInputs();
      @(posedge clk); #1;
      applyStimulus(vecs[0]);
      @(posedge clk); #1;
      clearInputs();
      ms_valid = 1'b1;
      ms_sys   = 1'b1;
      ms_eret  = 1'b1;
      int_req  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("stall%0d redirect_valid", k), {31'd0, redirect_valid}, 32'd1);
         checkOutput($sformatf("stall%0d redirect_pc", k), redirect_pc, 32'hBFC0_0380);
         checkOutput($sformatf("stall%0d commit_ok", k), {31'd0, ms_commit_ok}, 32'd0);
         checkOutput($sformatf("stall%0d exc_valid", k), {31'd0, exc_valid}, 32'd0);
         checkOutput($sformatf("stall%0d flush", k), {31'd0, flush}, 32'd0);
         @(posedge clk); #1;
      end
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      void'(sbq.pop_front());
      redirect_ready = 1'b0;
      clearInputs();
      ms_valid = 1'b1;
      ms_pc    = 32'h8000_1000;
      @(negedge clk);
      checkOutput("post-stall redirect_valid", {31'd0, redirect_valid}, 32'd0);
      checkOutput("post-stall commit_ok", {31'd0, ms_commit_ok}, 32'd1);
      checkOutput("post-stall no int exc_valid", {31'd0, exc_valid}, 32'd0);
      checkOutput("post-stall no int flush", {31'd0, flush}, 32'd0);
      @(posedge clk); #1;
      clearInputs();
      @(negedge clk);
      checkOutput("post-stall no redirect", {31'd0, redirect_valid}, 32'd0);

      // Async reset in the middle of a redirect, away from any clock edge
      @(posedge clk); #1;
      ms_valid = 1'b1;
      ms_pc    = 32'h8000_0300;
      ms_eret  = 1'b1;
      cp0_epc  = 32'h8000_2000;
      @(posedge clk); #1;
      clearInputs();
      @(negedge clk);
      checkOutput("pre-reset redirect_valid", {31'd0, redirect_valid}, 32'd1);
      checkOutput("pre-reset redirect_pc", redirect_pc, 32'h8000_2000);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("async reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
      checkOutput("async reset redirect_pc", redirect_pc, 32'd0);
      checkOutput("async reset commit_ok", {31'd0, ms_commit_ok}, 32'd1);
      #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      ms_valid = 1'b1;
      ms_pc    = 32'h8000_3000;
      @(negedge clk);
      checkOutput("after reset exc_valid", {31'd0, exc_valid}, 32'd0);
      checkOutput("after reset flush", {31'd0, flush}, 32'd0);
      checkOutput("after reset commit_ok", {31'd0, ms_commit_ok}, 32'd1);
      @(posedge clk); #1;
      clearInputs();
      @(negedge clk);
      checkOutput("after reset no redirect", {31'd0, redirect_valid}, 32'd0);

`ifdef EXC_TRAP_EN
      // Trap sits between Ov and Sys in priority
      @(posedge clk); #1;
      ms_valid = 1'b1;
      ms_pc    = 32'h8000_4000;
      ms_tr    = 1'b1;
      ms_sys   = 1'b1;
      sbq.push_back(32'h8000_0180);
      @(negedge clk);
      checkOutput("trap excode", {27'd0, exc_excode}, 32'h0000_000D);
      checkOutput("trap exc_valid", {31'd0, exc_valid}, 32'd1);
      @(posedge clk); #1;
      clearInputs();
      @(negedge clk);
      drainRedirect("trap");
      @(posedge clk); #1;
      ms_valid = 1'b1;
      ms_pc    = 32'h8000_4004;
      ms_tr    = 1'b1;
      ms_sys   = 1'b1;
      ms_ov    = 1'b1;
      sbq.push_back(32'h8000_0180);
      @(negedge clk);
      checkOutput("trap+ov excode", {27'd0, exc_excode}, 32'h0000_000C);
      @(posedge clk); #1;
      clearInputs();
      @(negedge clk);
      drainRedirect("trap+ov");
`endif

      checkOutput("scoreboard empty", sbq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
